// File: rtl/cpu_pkg.sv
// Shared opcode, ALU and state encodings for the bit-serial CPU sequencer.
// Also holds the instr field layout and the decoded-opcode bundle.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_SUBI = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_OUT  = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_PASSB = 3'd5,
        ALU_PASSA = 3'd6
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_WB
    } state_e;

    localparam int RD_LSB  = 0;
    localparam int RS_LSB  = 2;
    localparam int IMM_LSB = 4;
    localparam int IMM_W   = 8;

    typedef struct packed {
        logic    legal;
        alu_op_e alu_op;
        logic    src_b_imm;
        logic    writes_rd;
        logic    carry_init;
        logic    upd_flags;
        logic    is_out;
        logic    is_nop;
    } dec_t;

endpackage

// File: rtl/cpu_op_decode.sv
// Combinational opcode decoder; zero latency, no flow control.
// Undefined opcodes (0xC-0xF) come out with legal=0 and all strobes clear.
module cpu_op_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec        = '0;
        dec.legal  = 1'b1;
        dec.alu_op = ALU_ADD;
        case (opcode)
            OP_NOP: dec.is_nop = 1'b1;
            OP_ADD: begin
                dec.writes_rd = 1'b1;
                dec.upd_flags = 1'b1;
            end
            OP_SUB: begin
                dec.alu_op     = ALU_SUB;
                dec.writes_rd  = 1'b1;
                dec.carry_init = 1'b1;
                dec.upd_flags  = 1'b1;
            end
            OP_AND: begin
                dec.alu_op    = ALU_AND;
                dec.writes_rd = 1'b1;
                dec.upd_flags = 1'b1;
            end
            OP_OR: begin
                dec.alu_op    = ALU_OR;
                dec.writes_rd = 1'b1;
                dec.upd_flags = 1'b1;
            end
            OP_XOR: begin
                dec.alu_op    = ALU_XOR;
                dec.writes_rd = 1'b1;
                dec.upd_flags = 1'b1;
            end
            OP_ADDI: begin
                dec.src_b_imm = 1'b1;
                dec.writes_rd = 1'b1;
                dec.upd_flags = 1'b1;
            end
            OP_SUBI: begin
                dec.alu_op     = ALU_SUB;
                dec.src_b_imm  = 1'b1;
                dec.writes_rd  = 1'b1;
                dec.carry_init = 1'b1;
                dec.upd_flags  = 1'b1;
            end
            OP_LDI: begin
                dec.alu_op    = ALU_PASSB;
                dec.src_b_imm = 1'b1;
                dec.writes_rd = 1'b1;
            end
            OP_MOV: begin
                dec.alu_op    = ALU_PASSB;
                dec.writes_rd = 1'b1;
            end
            // rd recirculates through the rotate path since nothing is written
            OP_OUT: begin
                dec.alu_op = ALU_PASSA;
                dec.is_out = 1'b1;
            end
            OP_CMP: begin
                dec.alu_op     = ALU_SUB;
                dec.carry_init = 1'b1;
                dec.upd_flags  = 1'b1;
            end
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_exec_sequencer.sv
// Bit-serial CPU sequencer: DECODE 1 cycle, DATA_W LSB-first EXEC cycles, WB 1 cycle.
// stall freezes EXEC in place; instr_valid while busy is dropped with an overrun pulse.
module cpu_exec_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2,
    localparam int BW    = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [3:0]        opcode,
    input  logic [11:0]       instr,
    input  logic              stall,
    output logic              busy,
    output logic              shift_en,
    output logic [BW-1:0]     bit_idx,
    output logic              first_bit,
    output logic              last_bit,
    output logic              carry_init,
    output logic [2:0]        alu_op,
    output logic [REG_AW-1:0] rd_sel,
    output logic [REG_AW-1:0] rs_sel,
    output logic              src_b_imm,
    output logic              imm_bit,
    output logic              wr_en,
    output logic              flag_update,
    output logic              out_load,
    output logic              done,
    output logic              illegal,
    output logic              overrun
);

    localparam logic [BW-1:0] LAST_IDX = BW'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [REG_AW-1:0]   rs_q, rs_d;
    dec_t                dec_q, dec_d;
    dec_t                dec_in;
    logic                overrun_q, overrun_d;

    // Decoding the incoming opcode at accept time makes the fields valid during DECODE.
    cpu_op_decode u_dec (
        .opcode (opcode),
        .dec    (dec_in)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_q     <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            dec_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            dec_q     <= dec_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        dec_d     = dec_q;
        overrun_d = instr_valid && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    rd_d                 = instr[RD_LSB +: REG_AW];
                    rs_d                 = instr[RS_LSB +: REG_AW];
                    imm_d                = '0;
                    imm_d[IMM_W-1:0]     = instr[IMM_LSB +: IMM_W];
                    dec_d                = dec_in;
                    state_d              = ST_DECODE;
                end
            end
            ST_DECODE: begin
                bit_d = '0;
                if (!dec_q.legal) begin
                    state_d = ST_IDLE;
                end else if (dec_q.is_nop) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    imm_d = imm_q >> 1;
                    if (bit_q == LAST_IDX) begin
                        bit_d   = '0;
                        state_d = ST_WB;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Every output is a function of registered state, gated by stall only in EXEC.
    assign busy        = (state_q != ST_IDLE);
    assign shift_en    = (state_q == ST_EXEC) && !stall;
    assign bit_idx     = bit_q;
    assign first_bit   = shift_en && (bit_q == '0);
    assign last_bit    = shift_en && (bit_q == LAST_IDX);
    assign carry_init  = first_bit && dec_q.carry_init;
    assign alu_op      = dec_q.alu_op;
    assign rd_sel      = rd_q;
    assign rs_sel      = rs_q;
    assign src_b_imm   = dec_q.src_b_imm;
    assign imm_bit     = (state_q == ST_EXEC) && imm_q[0];
    assign wr_en       = shift_en && dec_q.writes_rd;
    assign flag_update = (state_q == ST_WB) && dec_q.upd_flags;
    assign out_load    = (state_q == ST_WB) && dec_q.is_out;
    assign done        = (state_q == ST_WB);
    assign illegal     = (state_q == ST_DECODE) && !dec_q.legal;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_cpu_exec_sequencer.sv
// Directed bench for cpu_exec_sequencer: inputs change on negedge, outputs sampled 1ns later.
module tb_cpu_exec_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [3:0]  opcode = '0;
    logic [11:0] instr = '0;
    logic        stall = 1'b0;
    logic        busy, shift_en, first_bit, last_bit, carry_init;
    logic [2:0]  bit_idx;
    logic [2:0]  alu_op;
    logic [1:0]  rd_sel, rs_sel;
    logic        src_b_imm, imm_bit, wr_en, flag_update, out_load, done, illegal, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_exec_sequencer #(.DATA_W(8), .REG_AW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .instr       (instr),
        .stall       (stall),
        .busy        (busy),
        .shift_en    (shift_en),
        .bit_idx     (bit_idx),
        .first_bit   (first_bit),
        .last_bit    (last_bit),
        .carry_init  (carry_init),
        .alu_op      (alu_op),
        .rd_sel      (rd_sel),
        .rs_sel      (rs_sel),
        .src_b_imm   (src_b_imm),
        .imm_bit     (imm_bit),
        .wr_en       (wr_en),
        .flag_update (flag_update),
        .out_load    (out_load),
        .done        (done),
        .illegal     (illegal),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Pulse instr_valid for one cycle and check the DECODE cycle that follows.
    task automatic issue(input logic [3:0] op, input logic [11:0] ins);
        opcode      = op;
        instr       = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        chk("dec_busy", busy, 1);
        chk("dec_shift_en", shift_en, 0);
        chk("dec_done", done, 0);
    endtask

    task automatic exec_pass(input string tag, input logic wr, input logic cin, input logic srcb,
                             input logic [2:0] alu, input logic [7:0] imm,
                             input logic [1:0] rd, input logic [1:0] rs);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk({tag, "_shift_en"}, shift_en, 1);
            chk({tag, "_bit_idx"}, bit_idx, i);
            chk({tag, "_first_bit"}, first_bit, i == 0);
            chk({tag, "_last_bit"}, last_bit, i == 7);
            chk({tag, "_carry_init"}, carry_init, (i == 0) ? cin : 1'b0);
            chk({tag, "_wr_en"}, wr_en, wr);
            chk({tag, "_imm_bit"}, imm_bit, imm[i]);
            chk({tag, "_src_b_imm"}, src_b_imm, srcb);
            chk({tag, "_alu_op"}, alu_op, alu);
            chk({tag, "_rd_sel"}, rd_sel, rd);
            chk({tag, "_rs_sel"}, rs_sel, rs);
            chk({tag, "_done_early"}, done, 0);
        end
    endtask

    task automatic wb(input string tag, input logic flag, input logic outl);
        @(negedge clk);
        #1;
        chk({tag, "_wb_done"}, done, 1);
        chk({tag, "_wb_flag"}, flag_update, flag);
        chk({tag, "_wb_out_load"}, out_load, outl);
        chk({tag, "_wb_shift_en"}, shift_en, 0);
        @(negedge clk);
        #1;
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_done"}, done, 0);
    endtask

    initial begin
        int want_bit;
        int s4;
        int s7;

        // Reset state
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_shift_en", shift_en, 0);
        chk("rst_bit_idx", bit_idx, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_rd_sel", rd_sel, 0);
        chk("rst_imm_bit", imm_bit, 0);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_overrun", overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ADD rd=1 rs=2
        issue(OP_ADD, 12'h009);
        chk("add_dec_rd", rd_sel, 1);
        chk("add_dec_rs", rs_sel, 2);
        chk("add_dec_alu", alu_op, ALU_ADD);
        chk("add_dec_illegal", illegal, 0);
        exec_pass("add", 1'b1, 1'b0, 1'b0, ALU_ADD, 8'h00, 2'd1, 2'd2);
        wb("add", 1'b1, 1'b0);

        // ADDI imm 0xA5 -> bits 1,0,1,0,0,1,0,1
        issue(OP_ADDI, 12'hA50);
        exec_pass("addi", 1'b1, 1'b0, 1'b1, ALU_ADD, 8'hA5, 2'd0, 2'd0);
        wb("addi", 1'b1, 1'b0);

        // SUBI imm 0x01
        issue(OP_SUBI, 12'h010);
        exec_pass("subi", 1'b1, 1'b1, 1'b1, ALU_SUB, 8'h01, 2'd0, 2'd0);
        wb("subi", 1'b1, 1'b0);

        // CMP: no writes, flags at WB
        issue(OP_CMP, 12'h009);
        exec_pass("cmp", 1'b0, 1'b1, 1'b0, ALU_SUB, 8'h00, 2'd1, 2'd2);
        wb("cmp", 1'b1, 1'b0);

        // OUT rd=1
        issue(OP_OUT, 12'h001);
        chk("out_dec_alu", alu_op, ALU_PASSA);
        exec_pass("out", 1'b0, 1'b0, 1'b0, ALU_PASSA, 8'h00, 2'd1, 2'd0);
        wb("out", 1'b0, 1'b1);

        // LDI rd=2 imm 0x3C: writes, no flags
        issue(OP_LDI, 12'h3C2);
        exec_pass("ldi", 1'b1, 1'b0, 1'b1, ALU_PASSB, 8'h3C, 2'd2, 2'd0);
        wb("ldi", 1'b0, 1'b0);

        // Illegal opcode 0xD
        issue(4'hD, 12'h000);
        chk("ill_pulse", illegal, 1);
        @(negedge clk);
        #1;
        chk("ill_busy", busy, 0);
        chk("ill_pulse_end", illegal, 0);
        chk("ill_done", done, 0);
        chk("ill_shift_en", shift_en, 0);

        // NOP retires at T+2
        issue(OP_NOP, 12'h000);
        @(negedge clk);
        #1;
        chk("nop_done", done, 1);
        chk("nop_shift_en", shift_en, 0);
        chk("nop_flag", flag_update, 0);
        @(negedge clk);
        #1;
        chk("nop_idle", busy, 0);

        // instr_valid during EXEC: overrun, fields untouched
        issue(OP_ADD, 12'h009);
        @(negedge clk);
        #1;
        chk("ovr_bit0", bit_idx, 0);
        opcode      = OP_AND;
        instr       = 12'hFFE;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        chk("ovr_pulse", overrun, 1);
        chk("ovr_bit1", bit_idx, 1);
        chk("ovr_rd", rd_sel, 1);
        chk("ovr_rs", rs_sel, 2);
        chk("ovr_alu", alu_op, ALU_ADD);
        @(negedge clk);
        #1;
        chk("ovr_pulse_end", overrun, 0);
        chk("ovr_bit2", bit_idx, 2);
        for (int i = 3; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk("ovr_bit", bit_idx, i);
            chk("ovr_shift_en", shift_en, 1);
        end
        wb("ovr", 1'b1, 1'b0);

        // Stall 3 cycles at bit 4 and 3 cycles at bit 7: 14 EXEC cycles
        issue(OP_ADD, 12'h009);
        want_bit = 0;
        s4 = 3;
        s7 = 3;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            stall = 1'b0;
            if (want_bit == 4 && s4 > 0) begin
                stall = 1'b1;
                s4--;
            end
            if (want_bit == 7 && s7 > 0) begin
                stall = 1'b1;
                s7--;
            end
            #1;
            chk("stl_shift_en", shift_en, !stall);
            chk("stl_bit_idx", bit_idx, want_bit);
            chk("stl_wr_en", wr_en, !stall);
            chk("stl_last_bit", last_bit, !stall && want_bit == 7);
            chk("stl_done", done, 0);
            if (!stall) want_bit++;
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        chk("stl_wb_done", done, 1);
        chk("stl_wb_flag", flag_update, 1);
        @(negedge clk);
        #1;
        chk("stl_idle", busy, 0);

        // Reset mid-EXEC at bit 3
        issue(OP_ADD, 12'h009);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("mrst_bit", bit_idx, i);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_shift_en", shift_en, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_wr_en", wr_en, 0);
        chk("mrst_bit_idx", bit_idx, 0);
        chk("mrst_rd", rd_sel, 0);
        chk("mrst_rs", rs_sel, 0);
        chk("mrst_done", done, 0);
        @(negedge clk);
        #1;
        chk("mrst_done_hold", done, 0);
        rst = 1'b0;
        @(negedge clk);
        issue(OP_ADD, 12'h009);
        exec_pass("post", 1'b1, 1'b0, 1'b0, ALU_ADD, 8'h00, 2'd1, 2'd2);
        wb("post", 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
